// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator: h/v counters, sync pulses,
// active-area flag and line/frame strobes, advanced by a pixel tick.
module vga_timing_gen #(
    parameter int WIDTH    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [WIDTH-1:0] H_LAST   = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_LAST   = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] HS_START = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] HS_END   = WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [WIDTH-1:0] VS_START = WIDTH'(V_ACTIVE + V_FP);
    localparam logic [WIDTH-1:0] VS_END   = WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [WIDTH-1:0] H_ACT_W  = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] V_ACT_W  = WIDTH'(V_ACTIVE);

    if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
        $error("vga_timing_gen: WIDTH out of range");
    end
    if ((64'd1 << WIDTH) < 64'(H_TOTAL) || (64'd1 << WIDTH) < 64'(V_TOTAL)) begin : g_bad_total
        $error("vga_timing_gen: WIDTH too small for H_TOTAL/V_TOTAL");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
        $error("vga_timing_gen: every region length must be at least 1");
    end

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_end_w;
    logic             frame_end_w;

    always_comb begin
        line_end_w  = en && (x_q == H_LAST);
        frame_end_w = line_end_w && (y_q == V_LAST);
    end

    // Decode from next-state counts so sync/active line up with x/y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            x_d = (x_q == H_LAST) ? '0 : x_q + 1'b1;
        end
        if (line_end_w) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
        hsync_d    = (x_d >= HS_START && x_d <= HS_END) ? H_POL : !H_POL;
        vsync_d    = (y_d >= VS_START && y_d <= VS_END) ? V_POL : !V_POL;
        video_on_d = (x_d < H_ACT_W) && (y_d < V_ACT_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= !H_POL;
            vsync_q    <= !V_POL;
            video_on_q <= 1'b1;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign line_end  = line_end_w;
    assign frame_end = frame_end_w;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing and a tiny
// 8x6 configuration driven with a sparse pixel tick.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst, d_en;
    logic       d_hs, d_vs, d_von, d_le, d_fe;
    logic [9:0] d_x, d_y;

    logic       s_rst, s_en;
    logic       s_hs, s_vs, s_von, s_le, s_fe;
    logic [3:0] s_x, s_y;

    int n_chk  = 0;
    int n_fail = 0;

    vga_timing_gen u_def (
        .clk(clk), .rst(d_rst), .en(d_en),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .x(d_x), .y(d_y), .line_end(d_le), .frame_end(d_fe)
    );

    vga_timing_gen #(
        .WIDTH(4),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(s_rst), .en(s_en),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .x(s_x), .y(s_y), .line_end(s_le), .frame_end(s_fe)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_def(input string tag, input int ex, input int ey,
                           input int ehs, input int evs, input int evon);
        chk({tag, ".x"}, int'(d_x), ex);
        chk({tag, ".y"}, int'(d_y), ey);
        chk({tag, ".hsync"}, int'(d_hs), ehs);
        chk({tag, ".vsync"}, int'(d_vs), evs);
        chk({tag, ".video_on"}, int'(d_von), evon);
    endtask

    int ticks, ex, ey, le_cnt, fe_cnt, fe_cyc;
    bit en_now;

    initial begin
        d_rst = 1'b1; d_en = 1'b1;
        s_rst = 1'b1; s_en = 1'b1;
        tick(3);
        chk_def("rst", 0, 0, 1, 1, 1);
        chk("rst.line_end", int'(d_le), 0);
        chk("rst.frame_end", int'(d_fe), 0);
        chk("rst_s.x", int'(s_x), 0);
        chk("rst_s.hsync", int'(s_hs), 0);
        chk("rst_s.vsync", int'(s_vs), 0);
        chk("rst_s.video_on", int'(s_von), 1);
        d_rst = 1'b0;
        s_en  = 1'b0;

        // Default config, continuous tick.
        tick(639); chk_def("x639", 639, 0, 1, 1, 1);
        tick(1);   chk_def("x640", 640, 0, 1, 1, 0);
        tick(15);  chk_def("x655", 655, 0, 1, 1, 0);
        tick(1);   chk_def("x656", 656, 0, 0, 1, 0);
        tick(95);  chk_def("x751", 751, 0, 0, 1, 0);
        tick(1);   chk_def("x752", 752, 0, 1, 1, 0);
        tick(46);
        chk("x798.line_end", int'(d_le), 0);
        tick(1);
        chk_def("x799", 799, 0, 1, 1, 0);
        chk("x799.line_end", int'(d_le), 1);
        chk("x799.frame_end", int'(d_fe), 0);
        tick(1);
        chk_def("y1x0", 0, 1, 1, 1, 1);
        chk("y1x0.line_end", int'(d_le), 0);

        // Tick held low mid-line.
        tick(300);
        d_en = 1'b0;
        #1;
        chk("hold.line_end0", int'(d_le), 0);
        tick(50);
        chk_def("hold", 300, 1, 1, 1, 1);
        chk("hold.line_end", int'(d_le), 0);
        chk("hold.frame_end", int'(d_fe), 0);
        d_en = 1'b1;
        tick(355); chk_def("y1x655", 655, 1, 1, 1, 0);
        tick(1);   chk_def("y1x656", 656, 1, 0, 1, 0);
        tick(143);
        chk_def("y1x799", 799, 1, 1, 1, 0);
        chk("y1x799.line_end", int'(d_le), 1);
        d_en = 1'b0;
        #1;
        chk("gated.line_end", int'(d_le), 0);
        d_en = 1'b1;
        tick(1);   chk_def("y2x0", 0, 2, 1, 1, 1);

        // Mid-frame reset.
        tick(300); chk_def("pre_rst", 300, 2, 1, 1, 1);
        d_rst = 1'b1;
        tick(1);   chk_def("mid_rst", 0, 0, 1, 1, 1);
        d_rst = 1'b0;
        tick(5);   chk_def("resume", 5, 0, 1, 1, 1);
        d_en = 1'b0;

        // Small config, tick every third cycle.
        s_rst = 1'b1; s_en = 1'b1;
        tick(1);
        s_rst = 1'b0;
        le_cnt = 0; fe_cnt = 0; fe_cyc = -1;
        for (int c = 0; c < 150; c++) begin
            en_now = (c % 3 == 0);
            s_en = en_now;
            #1;
            ticks = (c + 2) / 3;
            ex = ticks % 8;
            ey = (ticks / 8) % 6;
            chk($sformatf("s%0d.x", c), int'(s_x), ex);
            chk($sformatf("s%0d.y", c), int'(s_y), ey);
            chk($sformatf("s%0d.hsync", c), int'(s_hs),
                (ex == 5 || ex == 6) ? 1 : 0);
            chk($sformatf("s%0d.vsync", c), int'(s_vs), (ey == 4) ? 1 : 0);
            chk($sformatf("s%0d.video_on", c), int'(s_von),
                (ex < 4 && ey < 3) ? 1 : 0);
            chk($sformatf("s%0d.line_end", c), int'(s_le),
                (en_now && ex == 7) ? 1 : 0);
            chk($sformatf("s%0d.frame_end", c), int'(s_fe),
                (en_now && ex == 7 && ey == 5) ? 1 : 0);
            if (s_le) le_cnt++;
            if (s_fe) begin
                fe_cnt++;
                fe_cyc = c;
            end
            tick(1);
        end
        chk("s.line_end_count", le_cnt, 6);
        chk("s.frame_end_count", fe_cnt, 1);
        chk("s.frame_end_cycle", fe_cyc, 141);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parameterised VGA raster timing generator. It replaces the fixed pair of cascaded counters with a horizontal/vertical counter pair whose porch, sync and active lengths are parameters. It produces sync pulses with selectable polarity, a video-active flag, pixel coordinates and line/frame strobes. It sits between the pixel-clock enable logic and the pixel/colour generator.

## Interface

Parameters:
- `WIDTH`, 10: width of the counters and of `x`/`y`.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `H_POL`, 0: asserted level of `hsync`.
- `V_POL`, 0: asserted level of `vsync`.

Derived values:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).

Ports:
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `en`, input, 1: pixel tick. Counters advance only on cycles where `en`=1.
- `hsync`, output, 1: horizontal sync. Registered.
- `vsync`, output, 1: vertical sync. Registered.
- `video_on`, output, 1: high while (`x`,`y`) is inside the active area. Registered.
- `x`, output, WIDTH: current horizontal count, 0..H_TOTAL-1.
- `y`, output, WIDTH: current vertical count, 0..V_TOTAL-1.
- `line_end`, output, 1: single-cycle strobe, `en` && `x`==H_TOTAL-1. Combinational from registers and `en`.
- `frame_end`, output, 1: `line_end` && `y`==V_TOTAL-1.

## Operation

- Horizontal counter (`x`):
  - On a cycle with `en`=1, it increments.
  - At H_TOTAL-1 with `en`=1, it wraps to 0 and the vertical counter advances.
- Vertical counter (`y`):
  - Increments on `line_end`.
  - At V_TOTAL-1 with `line_end`, it wraps to 0.
- With `en`=0, all registers hold and both strobes are 0.
- Decode. These values hold in the same cycle as the `x`/`y` they describe:
  - `hsync` = H_POL when H_ACTIVE+H_FP ≤ `x` ≤ H_ACTIVE+H_FP+H_SYNC-1; otherwise !H_POL.
  - `vsync` = V_POL when V_ACTIVE+V_FP ≤ `y` ≤ V_ACTIVE+V_FP+V_SYNC-1; otherwise !V_POL.
  - `video_on` = (`x` < H_ACTIVE) && (`y` < V_ACTIVE).
- Registered decode outputs are computed from the next-state counter values. This keeps them cycle-aligned with `x`/`y` without extra latency.
- Width rule:
  - 2^WIDTH must be ≥ max(H_TOTAL, V_TOTAL). An elaboration-time check fails otherwise.
  - All comparisons use unsigned arithmetic at WIDTH bits. There are no intermediate overflows.
- Parameter rules: each of the eight region parameters must be ≥ 1. H_SYNC/V_SYNC spans may not wrap past the total.

## Timing

- Reset values, at the first edge with `rst`=1:
  - `x`=0, `y`=0.
  - `hsync`=!H_POL, `vsync`=!V_POL.
  - `video_on`=1, since (0,0) is active.
  - `line_end`=0 and `frame_end`=0, because they are gated by `en`.
- `rst` has priority over `en`. A reset mid-frame returns to (0,0) on the next edge, with no partial-line artefacts.
- Latency:
  - `x` changes on the edge following a cycle with `en`=1.
  - `hsync`/`vsync`/`video_on` change on that same edge.
- Simultaneous wrap: at (H_TOTAL-1, V_TOTAL-1) with `en`=1, both counters wrap on the same edge and `frame_end`=`line_end`=1 in that cycle.
- Defaults:
  - hsync is asserted for `x` in 656..751.
  - vsync is asserted for `y` in 490..491.
  - One frame is 420000 `en` ticks.
- `en` may be continuous (every cycle) or sparse. The outputs depend only on the number of ticks, not on the gaps between them.

## Test plan

- Reset: assert `rst` for 3 cycles with `en`=1 → `x`=0, `y`=0, `hsync`=1, `vsync`=1, `video_on`=1, strobes 0.
- Defaults, `en`=1 continuous:
  - `hsync` falls when `x` becomes 656 and rises when `x` becomes 752.
  - `video_on` falls at `x`=640.
  - `line_end` pulses once every 800 cycles.
  - `vsync` is low only for `y`=490..491.
  - `frame_end` pulses at cycle 419999.
- Small config (H 4/1/2/1, V 3/1/1/1, H_POL=V_POL=1), `en` every 3rd cycle:
  - `x` sequence is 0..7 and each value holds 3 cycles.
  - `hsync`=1 only at `x`=5,6.
  - `vsync`=1 only at `y`=4.
  - Frame = 48 ticks = 144 cycles.
- Simultaneous wrap in the small config: at `x`=7, `y`=5 with `en`=1 → `line_end`=`frame_end`=1 that cycle; next edge gives `x`=0, `y`=0, `video_on`=1.
- Reset mid-frame: `rst` at `x`=300, `y`=200 (defaults) → next edge gives `x`=0, `y`=0, `video_on`=1. Counting resumes from 0 after release.
- `en` held low for 50 cycles mid-line → all outputs frozen, strobes 0, no drift in the subsequent hsync position.
